// File: rtl/ms_game_ctrl.sv
// Game sequencer for the 5x5 minesweeper datapath.
// Takes cell picks, filters bad ones, and steps the datapath through a move.
module ms_game_ctrl #(
  parameter int NCELLS  = 25,
  parameter int CELL_W  = 5,
  parameter int TIMEOUT = 64,
  parameter int MOVE_W  = 5
) (
  input  logic              clka,
  input  logic              restart_n,
  input  logic              start_req,
  input  logic              in_valid,
  input  logic [CELL_W-1:0] in_cell,
  output logic              in_ready,
  input  logic              alu_done,
  input  logic              display_done,
  input  logic              gameover,
  input  logic              win,
  output logic              start,
  output logic              load,
  output logic              decode,
  output logic              alu,
  output logic              display,
  output logic [CELL_W-1:0] data,
  output logic              busy,
  output logic              game_over,
  output logic              game_won,
  output logic [MOVE_W-1:0] moves,
  output logic              bad_cell,
  output logic              err
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [CELL_W:0] NC = (CELL_W + 1)'(NCELLS);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_WAIT, S_LOAD, S_DEC,
    S_ALU, S_DISP, S_OVER, S_ERR
  } state_t;

  state_t state, nxt;

  logic [NCELLS-1:0] mask;
  logic [WD_W-1:0]   wd;
  logic in_range, seen, hs;
  logic accept, reject, latch, trip;

  // State register
  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) state <= S_IDLE;
    else            state <= nxt;
  end

  // Next-state and control decode
  always_comb begin
    nxt      = state;
    in_ready = 1'b0;
    start    = 1'b0;
    load     = 1'b0;
    decode   = 1'b0;
    alu      = 1'b0;
    display  = 1'b0;
    busy     = 1'b0;
    accept   = 1'b0;
    reject   = 1'b0;
    latch    = 1'b0;
    trip     = 1'b0;
    in_range = ({1'b0, in_cell} < NC);
    seen     = in_range ? mask[in_cell] : 1'b1;
    hs       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start_req) nxt = S_START;
      end
      S_START: begin
        start = 1'b1;
        nxt   = S_WAIT;
      end
      S_WAIT: begin
        in_ready = !start_req;
        hs       = in_valid && in_ready;
        if (start_req) begin
          nxt = S_START;
        end else if (hs && !seen) begin
          accept = 1'b1;
          nxt    = S_LOAD;
        end else if (hs) begin
          reject = 1'b1;
        end
      end
      S_LOAD: begin
        load = 1'b1;
        busy = 1'b1;
        nxt  = S_DEC;
      end
      S_DEC: begin
        decode = 1'b1;
        busy   = 1'b1;
        nxt    = S_ALU;
      end
      S_ALU: begin
        alu  = 1'b1;
        busy = 1'b1;
        // first cycle may still see the previous move's done flag
        if (alu_done && wd != '0) begin
          latch = 1'b1;
          nxt   = S_DISP;
        end else if (wd == WD_LAST) begin
          trip = 1'b1;
          nxt  = S_ERR;
        end
      end
      S_DISP: begin
        display = 1'b1;
        busy    = 1'b1;
        if (display_done && wd != '0) begin
          nxt = game_over ? S_OVER : S_WAIT;
        end else if (wd == WD_LAST) begin
          trip = 1'b1;
          nxt  = S_ERR;
        end
      end
      S_OVER, S_ERR: begin
        if (start_req) nxt = S_START;
      end
      default: nxt = S_IDLE;
    endcase
  end

  // Watchdog: counts cycles spent in ALU/DISP, zeroed on every state change
  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n)
      wd <= '0;
    else if (nxt != state)
      wd <= '0;
    else if (state == S_ALU || state == S_DISP)
      wd <= wd + 1'b1;
    else
      wd <= '0;
  end

  // Pick bookkeeping: accepted cell, picked mask, move count, reject pulse
  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      data     <= '0;
      mask     <= '0;
      moves    <= '0;
      bad_cell <= 1'b0;
    end else begin
      bad_cell <= reject;
      if (state == S_START) begin
        mask  <= '0;
        moves <= '0;
      end else if (accept) begin
        data          <= in_cell;
        mask[in_cell] <= 1'b1;
        if (moves != '1) moves <= moves + 1'b1;
      end
    end
  end

  // Game status flags and watchdog error
  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      game_over <= 1'b0;
      game_won  <= 1'b0;
      err       <= 1'b0;
    end else if (state == S_START) begin
      game_over <= 1'b0;
      game_won  <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (latch) begin
        game_over <= gameover;
        game_won  <= win;
      end
      if (trip) err <= 1'b1;
    end
  end

endmodule
